// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART receive framing FSM; define RX_MAJORITY_VOTE_EN for 2-of-3 sample voting.
`timescale 1ns/1ps
module rx_frame_ctrl (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic [2:0] error_flag,
  output logic [7:0] raw_data,
  output logic       start_bit,
  output logic       parity_bit,
  output logic       stop_bit,
  output logic       recieved_flag,
  output logic       data_valid,
  output logic [2:0] error_latched,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} state_t;
  state_t state, state_nx;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [1:0] par_cap;
  logic rx_s, mid, go;
`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] hist;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) hist <= 2'b11;
    else if (baud_tick) hist <= {hist[0], rx_in};
  assign rx_s = (rx_in & hist[0]) | (rx_in & hist[1]) | (hist[0] & hist[1]);
`else
  assign rx_s = rx_in;
`endif
  assign mid = baud_tick && tick_cnt == 4'd15;
  assign go = state == START && baud_tick && tick_cnt == 4'd7 && !rx_s;
  assign data_valid = state == CHECK;
  assign recieved_flag = data_valid;
  assign busy = state != IDLE;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (baud_tick && !rx_in) state_nx = START;
      START:   if (baud_tick && tick_cnt == 4'd7) state_nx = rx_s ? IDLE : DATA;
      DATA:    if (mid && bit_cnt == 3'd7) state_nx = ^par_cap ? PARITY : STOP;
      PARITY:  if (mid) state_nx = STOP;
      STOP:    if (mid) state_nx = CHECK;
      default: state_nx = IDLE;
    endcase
  end
  // frame fields persist until the next confirmed start bit
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      tick_cnt <= 4'd0;
      bit_cnt <= 3'd0;
      par_cap <= 2'b00;
      raw_data <= 8'h00;
      start_bit <= 1'b1;
      parity_bit <= 1'b1;
      stop_bit <= 1'b1;
      error_latched <= 3'b000;
    end else begin
      if (baud_tick)
        tick_cnt <= (state inside {DATA, PARITY, STOP} || (state == START && tick_cnt != 4'd7)) ? tick_cnt + 4'd1 : 4'd0;
      if (go) begin
        start_bit <= 1'b0;
        parity_bit <= 1'b1;
        bit_cnt <= 3'd0;
        par_cap <= parity_type;
      end
      if (state == DATA && mid) begin
        raw_data <= {rx_s, raw_data[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && mid) parity_bit <= rx_s;
      if (state == STOP && mid) stop_bit <= rx_s;
      if (state == CHECK) error_latched <= error_flag;
    end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: scoreboard bench for rx_frame_ctrl with a behavioural error checker.
`timescale 1ns/1ps
module tb_rx_frame_ctrl;
  logic clock = 1'b0, reset_n = 1'b0, baud_tick = 1'b0, rx_in = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic [2:0] error_flag, error_latched;
  logic [7:0] raw_data;
  logic start_bit, parity_bit, stop_bit, recieved_flag, data_valid, busy;
  int n_tests = 0, n_fail = 0, tick_no = 0;
  logic cur_par_en = 1'b0, cur_odd = 1'b0;
  typedef struct {logic [7:0] data; logic par; logic stp; logic [2:0] err; int t0; int lat;} exp_t;
  exp_t sb[$];
  exp_t cur;
  logic pend = 1'b0;
  logic [2:0] pend_err;

  always #5 clock = ~clock;
  assign error_flag = recieved_flag ? {~stop_bit, start_bit, cur_par_en & (^{raw_data, parity_bit} ^ cur_odd)} : 3'b000;

  rx_frame_ctrl dut (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .rx_in(rx_in),
    .parity_type(parity_type), .error_flag(error_flag), .raw_data(raw_data),
    .start_bit(start_bit), .parity_bit(parity_bit), .stop_bit(stop_bit),
    .recieved_flag(recieved_flag), .data_valid(data_valid),
    .error_latched(error_latched), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input logic r);
    rx_in = r;
    baud_tick = 1'b1;
    tick_no++;
    @(posedge clock);
    #1 baud_tick = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic v, input int glitch_at);
    for (int k = 0; k < 16; k++) do_tick(k == glitch_at ? ~v : v);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [7:0] exp_d, input logic [1:0] pt,
                            input logic stop_v, input logic par_bad, input int glitch_bit, input logic [1:0] pt_mid);
    logic pe, p;
    exp_t e;
    pe = pt == 2'b01 || pt == 2'b10;
    p = ((pt == 2'b01) ? ~^d : ^d) ^ par_bad;
    parity_type = pt;
    cur_par_en = pe;
    cur_odd = pt == 2'b01;
    do_tick(1'b1);
    do_tick(1'b1);
    e.data = exp_d;
    e.par = pe ? p : 1'b1;
    e.stp = stop_v;
    e.err = {~stop_v, 1'b0, pe & par_bad};
    e.t0 = tick_no + 1;
    e.lat = pe ? 169 : 153;
    sb.push_back(e);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], i == glitch_bit ? 8 : -1);
      if (i == 3) parity_type = pt_mid;
    end
    if (pe) send_bit(p, -1);
    for (int k = 0; k < 16; k++) do_tick(k <= 8 ? stop_v : 1'b1);
    chk("frame_consumed", sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (pend) begin
      chk("error_latched", error_latched, pend_err);
      pend = 1'b0;
    end
    if (data_valid) begin
      if (sb.size() == 0) chk("unexpected_data_valid", data_valid, 0);
      else begin
        cur = sb.pop_front();
        chk("raw_data", raw_data, cur.data);
        chk("parity_bit", parity_bit, cur.par);
        chk("stop_bit", stop_bit, cur.stp);
        chk("start_bit", start_bit, 0);
        chk("recieved_flag", recieved_flag, 1);
        chk("latency", tick_no - cur.t0 + 1, cur.lat);
        pend = 1'b1;
        pend_err = cur.err;
      end
    end
  end

  task automatic chk_reset(input string pfx);
    chk({pfx, "_raw_data"}, raw_data, 8'h00);
    chk({pfx, "_start_bit"}, start_bit, 1);
    chk({pfx, "_parity_bit"}, parity_bit, 1);
    chk({pfx, "_stop_bit"}, stop_bit, 1);
    chk({pfx, "_recieved_flag"}, recieved_flag, 0);
    chk({pfx, "_data_valid"}, data_valid, 0);
    chk({pfx, "_error_latched"}, error_latched, 3'b000);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: timeout at tick %0d", tick_no);
    $fatal(1);
  end

  initial begin
    #12 chk_reset("rst0");
    #5 reset_n = 1'b1;
    @(posedge clock);
    #1;
    send_frame(8'hA5, 8'hA5, 2'b10, 1'b1, 1'b0, -1, 2'b10);
    send_frame(8'h3C, 8'h3C, 2'b00, 1'b1, 1'b0, -1, 2'b00);
    do_tick(1'b1);
    for (int k = 0; k < 4; k++) do_tick(1'b0);
    for (int k = 0; k < 4; k++) do_tick(1'b1);
    chk("false_start_busy_before", busy, 1);
    do_tick(1'b1);
    chk("false_start_busy_after", busy, 0);
    for (int k = 0; k < 8; k++) do_tick(1'b1);
    chk("false_start_raw_data", raw_data, 8'h3C);
    chk("false_start_start_bit", start_bit, 0);
    send_frame(8'h01, 8'h01, 2'b01, 1'b0, 1'b0, -1, 2'b01);
    send_frame(8'h5A, 8'h5A, 2'b01, 1'b1, 1'b1, -1, 2'b01);
    parity_type = 2'b00;
    do_tick(1'b1);
    send_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, -1);
    for (int k = 0; k < 5; k++) do_tick(1'b1);
    chk("mid_frame_busy", busy, 1);
    #3 reset_n = 1'b0;
    #1 chk_reset("rst_mid");
    rx_in = 1'b1;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    send_frame(8'hFF, 8'hFF, 2'b10, 1'b1, 1'b0, -1, 2'b00);
`ifdef RX_MAJORITY_VOTE_EN
    send_frame(8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 2, 2'b00);
`else
    send_frame(8'h00, 8'h04, 2'b00, 1'b1, 1'b0, 2, 2'b00);
`endif
    repeat (4) do_tick(1'b1);
    chk("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port baud_tick, input, 1, one-clock strobe at 16x the baud rate.
REQ-004 SHALL have port rx_in, input, 1, serial line, idle high.
REQ-005 SHALL have port parity_type, input, 2, 01=ODD, 10=EVEN, 00/11=no parity.
REQ-006 SHALL have port error_flag, input, 3, from error checker: {stop,start,parity}.
REQ-007 SHALL have port raw_data, output, 8, assembled data byte, LSB first on the line.
REQ-008 SHALL have ports start_bit, parity_bit and stop_bit, output, 1 each, sampled frame fields.
REQ-009 SHALL have port recieved_flag, output, 1, one-clock enable to the error checker.
REQ-010 SHALL have port data_valid, output, 1, one-clock pulse: frame complete.
REQ-011 SHALL have port error_latched, output, 3, error_flag captured at frame end.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, CHECK, plus a 4-bit tick counter and a 3-bit bit counter.
REQ-014 SHALL advance the FSM and counters only on clocks with baud_tick=1, except CHECK, which lasts exactly one clock.
REQ-015 IDLE: on baud_tick with sampled rx=0, go to START with tick counter=0.
REQ-016 START: tick counter increments per tick; at count 7, sampled rx=1 means false start (return to IDLE, no outputs change); rx=0 sets start_bit=0, clears the tick counter and bit counter, captures parity_type, and goes to DATA.
REQ-017 DATA: sample at tick count 15 (bit centre); shift the sample into raw_data[7] while shifting right; increment the bit counter; after the 8th bit go to PARITY if the captured type is 01/10, else STOP.
REQ-018 PARITY: sample at tick count 15 into parity_bit, then go to STOP.
REQ-019 No-parity frames SHALL drive parity_bit=1 so the error checker reports no parity error.
REQ-020 STOP: sample at tick count 15 into stop_bit and go to CHECK regardless of value; a break (stop=0) is reported, not discarded.
REQ-021 CHECK: assert recieved_flag and data_valid for exactly this clock, load error_latched from error_flag in the same clock, then go to IDLE.
REQ-022 raw_data, start_bit, parity_bit, stop_bit and error_latched SHALL hold until the next confirmed start bit.
REQ-023 Frame latency SHALL be 8+16*(9+P) ticks from the first low sample to CHECK (P=1 with parity), plus 1 clock.
REQ-024 Changes to parity_type mid-frame SHALL have no effect until the next start.
REQ-025 A new falling edge during CHECK SHALL be detected by IDLE on the next tick.

Reset
REQ-026 reset_n=0 SHALL force IDLE immediately, at any point including mid-frame.
REQ-027 Reset SHALL set counters=0, raw_data=8'h00, start_bit=1, parity_bit=1, stop_bit=1, recieved_flag=0, data_valid=0, error_latched=3'b000 and busy=0.
REQ-028 After reset release, the first frame SHALL be recognised only from a fresh low sample.

Configuration
REQ-029 Macro RX_MAJORITY_VOTE_EN defined: each decision sample (START count 7, others count 15) SHALL be the 2-of-3 majority of rx at the decision tick and the two preceding ticks.
REQ-030 Macro RX_MAJORITY_VOTE_EN undefined: each decision sample SHALL be the single rx value at the decision tick; timing is identical either way.

Verification
REQ-031 EVEN parity, byte 8'hA5, parity=0, stop=1 -> raw_data=8'hA5, error_latched=000, one data_valid pulse 169 ticks after the start edge (+1 clock).
REQ-032 No parity, 8'h3C -> PARITY state skipped, parity_bit=1, raw_data=8'h3C, data_valid after 153 ticks (+1 clock).
REQ-033 rx low for 4 ticks, then high -> return to IDLE at count 7, no data_valid, busy=0.
REQ-034 ODD parity, 8'h01, stop bit driven 0 -> data_valid pulses; error_latched[2]=1 given a checker-reported stop error.
REQ-035 reset_n pulsed low during DATA bit 4 -> immediate IDLE with all REQ-027 values; the next full frame 8'hFF is received correctly.
REQ-036 With RX_MAJORITY_VOTE_EN, a 1-tick glitch at the centre of data bit 2 of 8'h00 -> raw_data=8'h00; without it -> raw_data=8'h04.
